// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with pipelined sync/de alignment and RGB blanking.
// Coordinates are undelayed; sync/de/colour trail them by PIPE_DELAY edges.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BP       = 88,
   parameter int V_ACTIVE   = 600,
   parameter int V_FP       = 1,
   parameter int V_SYNC     = 4,
   parameter int V_BP       = 23,
   parameter bit HS_POL     = 1'b1,
   parameter bit VS_POL     = 1'b1,
   parameter int PIPE_DELAY = 2,
   parameter int COLOR_W    = 4,
   parameter int FRAME_W    = 16,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW        = $clog2(H_TOTAL),
   localparam int VW        = $clog2(V_TOTAL)
) (
   input  logic                 vga_clk,
   input  logic                 reset,
   output logic [HW-1:0]        pix_x,
   output logic [VW-1:0]        pix_y,
   output logic                 pix_req,
   output logic                 frame_start,
   output logic [FRAME_W-1:0]   frame_count,
   input  logic [3*COLOR_W-1:0] pix_rgb,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_de,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b
);
   localparam int D = PIPE_DELAY + 1;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_param
      $error("vga_timing_gen: illegal timing parameters");
   end

   logic [HW-1:0]      r_h, w_nxt_h;
   logic [VW-1:0]      r_v, w_nxt_v;
   logic               r_run;
   logic [FRAME_W-1:0] r_frame;
   logic               w_h_last, w_v_last, w_de, w_hs, w_vs;
   logic [D-1:0]       r_de_d, r_hs_d, r_vs_d, w_de_sh, w_hs_sh, w_vs_sh;
   logic [COLOR_W-1:0] r_r, r_g, r_b;

   assign w_h_last = r_h == H_LAST;
   assign w_v_last = r_v == V_LAST;

   // r_run holds the counters at 0,0 for the first edge after reset release
   always_comb begin
      w_nxt_h = (r_run && !w_h_last) ? r_h + 1'b1 : '0;
      w_nxt_v = (!r_run || (w_h_last && w_v_last)) ? '0 : w_h_last ? r_v + 1'b1 : r_v;
      w_de    = (w_nxt_h < H_ACT) && (w_nxt_v < V_ACT);
      w_hs    = (w_nxt_h >= H_HS0) && (w_nxt_h < H_HS1);
      w_vs    = (w_nxt_v >= V_VS0) && (w_nxt_v < V_VS1);
      w_de_sh = (r_de_d << 1) | D'(w_de);
      w_hs_sh = (r_hs_d << 1) | D'(w_hs);
      w_vs_sh = (r_vs_d << 1) | D'(w_vs);
   end

   always_ff @(posedge vga_clk) begin
      if (!reset) begin
         r_h     <= '0;
         r_v     <= '0;
         r_run   <= 1'b0;
         r_frame <= '0;
         r_de_d  <= '0;
         r_hs_d  <= '0;
         r_vs_d  <= '0;
         {r_r, r_g, r_b} <= '0;
      end else begin
         r_h     <= w_nxt_h;
         r_v     <= w_nxt_v;
         r_run   <= 1'b1;
         r_frame <= (r_run && w_h_last && w_v_last) ? r_frame + 1'b1 : r_frame;
         r_de_d  <= w_de_sh;
         r_hs_d  <= w_hs_sh;
         r_vs_d  <= w_vs_sh;
         {r_r, r_g, r_b} <= w_de_sh[PIPE_DELAY] ? pix_rgb : '0;
      end
   end

   assign pix_x       = r_h;
   assign pix_y       = r_v;
   assign pix_req     = r_run && (r_h < H_ACT) && (r_v < V_ACT);
   assign frame_start = r_run && (r_h == '0) && (r_v == '0);
   assign frame_count = r_frame;
   assign vga_de      = r_de_d[PIPE_DELAY];
   assign vga_hs      = r_hs_d[PIPE_DELAY] ~^ HS_POL;
   assign vga_vs      = r_vs_d[PIPE_DELAY] ~^ VS_POL;
   assign vga_r       = r_r;
   assign vga_g       = r_g;
   assign vga_b       = r_b;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two configurations checked every cycle against an arithmetic raster model
// (position = cycles since release modulo frame size), with random pixel data and random resets.
module tb_vga_timing_gen;
   logic vga_clk = 1'b0;
   logic reset   = 1'b0;
   always #5 vga_clk = ~vga_clk;

   logic [2:0]  ax, ay;
   logic        areq, afs, ahs, avs, ade;
   logic [1:0]  afc;
   logic [11:0] a_rgb = '0, a_last = '0;
   logic [3:0]  ar, ag, ab;

   logic [4:0]  bx, by;
   logic        breq, bfs, bhs, bvs, bde;
   logic [2:0]  bfc;
   logic [11:0] b_rgb = '0, b_last = '0;
   logic [3:0]  br, bg, bb;

   int n = -1;
   int vec = 0;
   int bad = 0;

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(0), .COLOR_W(4), .FRAME_W(2)
   ) u_a (
      .vga_clk(vga_clk), .reset(reset), .pix_x(ax), .pix_y(ay), .pix_req(areq),
      .frame_start(afs), .frame_count(afc), .pix_rgb(a_rgb), .vga_hs(ahs), .vga_vs(avs),
      .vga_de(ade), .vga_r(ar), .vga_g(ag), .vga_b(ab)
   );

   vga_timing_gen #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(3), .COLOR_W(4), .FRAME_W(3)
   ) u_b (
      .vga_clk(vga_clk), .reset(reset), .pix_x(bx), .pix_y(by), .pix_req(breq),
      .frame_start(bfs), .frame_count(bfc), .pix_rgb(b_rgb), .vga_hs(bhs), .vga_vs(bvs),
      .vga_de(bde), .vga_r(br), .vga_g(bg), .vga_b(bb)
   );

   typedef struct packed {
      int x;
      int y;
      int fc;
      bit req;
      bit fs;
      bit de;
      bit hs;
      bit vs;
   } exp_t;

   // n = edges since reset release (-1 while in reset); delayed outputs look at n-pd
   function automatic exp_t model(input int n_i, input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input bit hp, input bit vp, input int pd, input int fw);
      exp_t e;
      int ht, vt, t, i, m, xm, ym;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      t  = ht * vt;
      e  = '0;
      e.hs = !hp;
      e.vs = !vp;
      if (n_i >= 0) begin
         i    = n_i % t;
         e.x  = i % ht;
         e.y  = i / ht;
         e.req = (e.x < ha) && (e.y < va);
         e.fs = (i == 0);
         e.fc = (n_i / t) % (1 << fw);
      end
      m = n_i - pd;
      if (n_i >= 0 && m >= 0) begin
         i  = m % t;
         xm = i % ht;
         ym = i / ht;
         e.de = (xm < ha) && (ym < va);
         e.hs = (xm >= ha + hf && xm < ha + hf + hsw) ? hp : !hp;
         e.vs = (ym >= va + vf && ym < va + vf + vsw) ? vp : !vp;
      end
      return e;
   endfunction

   function automatic exp_t model_a(input int n_i);
      return model(n_i, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0, 2);
   endfunction

   function automatic exp_t model_b(input int n_i);
      return model(n_i, 20, 3, 5, 4, 10, 2, 3, 2, 1'b0, 1'b0, 3, 3);
   endfunction

   task automatic chk(input string tag, input int got, input int want);
      vec++;
      if (got != want) begin
         bad++;
         $display("FAIL %s at n=%0d: got %0d, want %0d", tag, n, got, want);
      end
   endtask

   task automatic step(input bit rst);
      exp_t ea, eb, ec;
      reset = !rst;
      a_rgb = 12'($urandom);
      // framebuffer for B returns the pixel whose coordinates appeared 3 edges before capture
      ec = model_b(n + 1 - 3);
      b_rgb = (!rst && n + 1 - 3 >= 0) ? {4'(ec.x), 4'(ec.y), 4'($urandom)} : 12'($urandom);
      @(posedge vga_clk);
      n = rst ? -1 : n + 1;
      a_last = a_rgb;
      b_last = b_rgb;
      @(negedge vga_clk);
      ea = model_a(n);
      eb = model_b(n);
      chk("a_x", int'(ax), ea.x);
      chk("a_y", int'(ay), ea.y);
      chk("a_req", int'(areq), int'(ea.req));
      chk("a_fs", int'(afs), int'(ea.fs));
      chk("a_fc", int'(afc), ea.fc);
      chk("a_de", int'(ade), int'(ea.de));
      chk("a_hs", int'(ahs), int'(ea.hs));
      chk("a_vs", int'(avs), int'(ea.vs));
      chk("a_rgb", int'({ar, ag, ab}), ea.de ? int'(a_last) : 0);
      chk("b_x", int'(bx), eb.x);
      chk("b_y", int'(by), eb.y);
      chk("b_req", int'(breq), int'(eb.req));
      chk("b_fs", int'(bfs), int'(eb.fs));
      chk("b_fc", int'(bfc), eb.fc);
      chk("b_de", int'(bde), int'(eb.de));
      chk("b_hs", int'(bhs), int'(eb.hs));
      chk("b_vs", int'(bvs), int'(eb.vs));
      chk("b_rgb", int'({br, bg, bb}), eb.de ? int'(b_last) : 0);
   endtask

   initial begin
      repeat (3) step(1'b1);
      repeat (4500) step(1'b0);
      repeat (1000) step($urandom_range(0, 39) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator for the GPU's `vga_clk` domain. It produces horizontal/vertical sync, data-enable and pixel coordinates for any resolution and sync polarity. It delays sync/enable by a configurable number of cycles so they line up with a pipelined framebuffer read, and blanks the RGB outputs outside the active area. It replaces the fixed-mode timing logic inside the GPU video-out path and drives `vga_hs`, `vga_vs`, `vga_r/g/b` directly.

## Interface

Parameters:
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 128: horizontal sync width, in pixels.
- `H_BP`, 88: horizontal back porch, in pixels.
- `V_ACTIVE`, 600: visible lines per frame.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vertical sync width, in lines.
- `V_BP`, 23: vertical back porch, in lines.
- `HS_POL`, 1: hsync active level (1 = positive).
- `VS_POL`, 1: vsync active level (1 = positive).
- `PIPE_DELAY`, 2: cycles between coordinate output and returned pixel data. Range 0..15.
- `COLOR_W`, 4: bits per colour channel.
- `FRAME_W`, 16: frame counter width.

Ports:
- `vga_clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-low reset (0 = in reset).
- `pix_x`  out  clog2(H_TOTAL)  current horizontal count, undelayed.
- `pix_y`  out  clog2(V_TOTAL)  current vertical count, undelayed.
- `pix_req`  out  1  high when (`pix_x`,`pix_y`) is inside the active area, undelayed.
- `frame_start`  out  1  one-cycle pulse when `pix_x`=0 and `pix_y`=0.
- `frame_count`  out  FRAME_W  number of completed frames; wraps to 0.
- `pix_rgb`  in  3*COLOR_W  pixel data {r,g,b}, valid PIPE_DELAY cycles after the matching `pix_req`.
- `vga_hs`  out  1  horizontal sync, delayed.
- `vga_vs`  out  1  vertical sync, delayed.
- `vga_de`  out  1  data enable, delayed.
- `vga_r`, `vga_g`, `vga_b`  out  COLOR_W each  blanked colour outputs.

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Horizontal counter `h` counts 0..H_TOTAL-1. On wrap it returns to 0 and advances vertical counter `v`, which counts 0..V_TOTAL-1.
- When `v` wraps to 0, `frame_count` increments modulo 2^FRAME_W.
- Region order within both a line and a frame: active, front porch, sync, back porch.
- Raw hsync is asserted for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Raw vsync is asserted for `v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Vsync transitions coincide with `h`=0.
- Raw de = (h<H_ACTIVE) && (v<V_ACTIVE).
- Raw hs, vs and de pass through a PIPE_DELAY-stage shift register before driving `vga_hs`, `vga_vs` and `vga_de`. With PIPE_DELAY=0 they are registered once, with the same timing as `pix_x`.
- Polarity is applied after the delay: `vga_hs` = raw_hs_delayed XNOR HS_POL, i.e. inactive level = !HS_POL. `vga_vs` is handled the same way with VS_POL.
- `vga_r/g/b` = `pix_rgb` fields registered when delayed de = 1, and 0 otherwise. The colour register is in the same stage as `vga_de`, so colour and enable change on the same edge.
- Parameter legality: each of the eight porch/sync/active parameters ≥ 1. Illegal values are a compile-time error (`$error` in an initial check).

## Timing

- Reset is sampled on `vga_clk` rising edge while `reset`=0. All of the following take effect on that edge:
  - `h`, `v`, `frame_count` = 0.
  - `vga_de` = 0, `vga_r/g/b` = 0.
  - `vga_hs` = !HS_POL, `vga_vs` = !VS_POL.
  - All delay stages cleared (de=0, sync inactive).
  - `frame_start` = 0, `pix_req` = 0.
- First edge with `reset`=1: `pix_x`=0, `pix_y`=0, `frame_start`=1, `pix_req`=1. Counting continues on every edge after that.
- Raw sync/de changes appear on `vga_*` exactly PIPE_DELAY edges after the corresponding `pix_x`/`pix_y` value.
- Reset asserted mid-frame: outputs go to reset values on the next edge. No partial-line completion.
- Wrap at the last pixel of the frame (`h`=H_TOTAL-1, `v`=V_TOTAL-1): the next edge gives h=0, v=0, frame_start=1, frame_count+1, all in the same cycle.
- `frame_count` at 2^FRAME_W-1 wraps to 0.
- Throughput: one pixel per clock; there is no back-pressure.

## Test plan

- Default params, release reset: `frame_start` pulses on the first edge. `frame_count`=1 exactly 1056×628=663168 cycles later. hs period = 1056 cycles with high width 128; vs high width = 4×1056 cycles.
- Small mode (H 4/1/2/1, V 3/1/1/1, PIPE_DELAY=0): `vga_hs` rises at h=5 and falls at h=7. `vga_de` high for h 0..3 on v 0..2. 48 cycles per frame.
- PIPE_DELAY=3, `pix_rgb` = {h[3:0], v[3:0], 4'hA} delayed 3 cycles: `vga_de` rising edge is 3 cycles after the `pix_req` rising edge. `vga_r` equals the x of the matching `pix_x`; r/g/b = 0 whenever `vga_de`=0.
- HS_POL=0, VS_POL=0: during and directly after reset `vga_hs`=`vga_vs`=1. Both go low only inside their sync windows.
- Assert `reset`=0 at h=300, v=200 for one cycle: next edge gives `pix_x`=0, `vga_de`=0, `frame_count`=0. The cycle after release gives `frame_start`=1.
- FRAME_W=2 with the small mode: after 4 frames (192 cycles) `frame_count` reads 0 again.
